// File: rtl/filter_config_sequencer.sv
// filter_config_sequencer
//   Frame-synchronous scheduler for the Filter_Pipe configuration. On each
//   falling edge of LTM_VD it snapshots the requested filter mode (from the
//   switches, or from an auto-cycling mode counter) together with the flag.
//   The snapshot is committed to the pipe only once the pipe reports idle, so
//   the filter mode never changes in the middle of a frame.
//
//   Optional feature macro: FILTER_CFG_DEFER_CNT_EN
//     defined   -> Deferred_count port exists (saturating count of deferrals)
//     undefined -> no Deferred_count port, no counter
//
// Ports
//   Clock           in   system clock
//   Reset           in   synchronous, active-high reset
//   Enable          in   sequencer enable (LCD running)
//   LTM_VD          in   vertical sync, low during sync, same clock domain
//   Pipe_idle       in   pipe drained, safe to reconfigure
//   Sw_config       in   requested mode in manual mode
//   Sw_flag         in   requested flag value
//   Auto_mode       in   1 = cycle modes automatically, 0 = use Sw_config
//   Frame_period    in   frames per auto step (0 behaves as 1)
//   Filter_config   out  committed config, mode zero-extended to CFG_W
//   Flag            out  committed flag
//   Cfg_update      out  one-cycle pulse after a commit
//   Cfg_pending     out  high while a snapshot waits for Pipe_idle
//   Frame_count     out  vsync falling edges seen while enabled (wraps)
//   Deferred_count  out  deferral count, FILTER_CFG_DEFER_CNT_EN only
//
// States
//   state        | meaning
//   ST_IDLE      | sequencer disabled, nothing snapshotted
//   ST_ARMED     | enabled, waiting for the next vsync falling edge
//   ST_WAIT_IDLE | snapshot held, waiting for Pipe_idle or end of sync window
module filter_config_sequencer #(
   parameter int NUM_MODES = 5,
   parameter int CFG_W     = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             LTM_VD,
   input  logic             Pipe_idle,
   input  logic [2:0]       Sw_config,
   input  logic [1:0]       Sw_flag,
   input  logic             Auto_mode,
   input  logic [7:0]       Frame_period,
   output logic [CFG_W-1:0] Filter_config,
   output logic [1:0]       Flag,
   output logic             Cfg_update,
   output logic             Cfg_pending,
   output logic [15:0]      Frame_count
`ifdef FILTER_CFG_DEFER_CNT_EN
   ,
   output logic [7:0]       Deferred_count
`endif
);

   localparam logic [3:0] NUM_MODES_L = 4'(NUM_MODES);
   localparam logic [2:0] MODE_LAST   = 3'(NUM_MODES - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_WAIT_IDLE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        vd_q;
   logic        fe;
   logic        step_en;
   logic [7:0]  period_lim;
   logic [2:0]  mode_cnt;
   logic [2:0]  mode_step;
   logic [7:0]  period_cnt;
   logic [7:0]  period_step;
   logic [2:0]  req_mode;
   logic [2:0]  snap_mode;
   logic [1:0]  snap_flag;
   logic        snap_en;
   logic        commit;
   logic        defer;

   // Falling edge of vsync and the post-step auto mode. The snapshot must see
   // the stepped value, so the step is computed combinationally here.
   always_comb begin
      fe          = vd_q & ~LTM_VD;
      step_en     = fe & Enable & Auto_mode;
      period_lim  = (Frame_period == 8'd0) ? 8'd0 : Frame_period - 8'd1;
      mode_step   = mode_cnt;
      period_step = period_cnt;
      if (step_en) begin
         if (period_cnt >= period_lim) begin
            period_step = 8'd0;
            mode_step   = (mode_cnt == MODE_LAST) ? 3'd0 : mode_cnt + 3'd1;
         end else begin
            period_step = period_cnt + 8'd1;
         end
      end
      req_mode = Auto_mode ? mode_step : Sw_config;
      if ({1'b0, req_mode} >= NUM_MODES_L) begin
         req_mode = 3'd0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Enable low overrides everything, including a pending commit.
   always_comb begin
      state_next = state;
      snap_en    = 1'b0;
      commit     = 1'b0;
      defer      = 1'b0;
      if (!Enable) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               state_next = ST_ARMED;
            end
            ST_ARMED: begin
               if (fe) begin
                  state_next = ST_WAIT_IDLE;
                  snap_en    = 1'b1;
               end
            end
            ST_WAIT_IDLE: begin
               if (Pipe_idle) begin
                  state_next = ST_ARMED;
                  commit     = 1'b1;
               end else if (LTM_VD) begin
                  // sync window over while the pipe is still busy: drop it
                  state_next = ST_ARMED;
                  defer      = 1'b1;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign Cfg_pending = (state == ST_WAIT_IDLE);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         vd_q          <= 1'b1;
         mode_cnt      <= 3'd0;
         period_cnt    <= 8'd0;
         snap_mode     <= 3'd0;
         snap_flag     <= 2'd0;
         Filter_config <= '0;
         Flag          <= 2'd0;
         Cfg_update    <= 1'b0;
         Frame_count   <= 16'd0;
      end else begin
         vd_q       <= LTM_VD;
         Cfg_update <= commit;
         if (step_en) begin
            mode_cnt   <= mode_step;
            period_cnt <= period_step;
         end
         if (snap_en) begin
            snap_mode <= req_mode;
            snap_flag <= Sw_flag;
         end
         if (commit) begin
            Filter_config <= CFG_W'(snap_mode);
            Flag          <= snap_flag;
         end
         if (fe && Enable && (state != ST_IDLE)) begin
            Frame_count <= Frame_count + 16'd1;
         end
      end
   end

`ifdef FILTER_CFG_DEFER_CNT_EN
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Deferred_count <= 8'd0;
      end else if (defer && (Deferred_count != 8'hFF)) begin
         Deferred_count <= Deferred_count + 8'd1;
      end
   end
`endif

endmodule
